// File: rtl/demux12_2bits_fifo_if.sv
// Upstream push handshake and per-lane drain signals
// for the 1:2 lane-splitting demux.
interface demux12_2bits_fifo_if #(
    parameter int DATA_W = 2,
    parameter int CNT_W  = 3
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              selector;
    logic              ready_out;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out0;
    logic              valid_out1;
    logic              pop0;
    logic              pop1;
    logic [CNT_W-1:0]  count0;
    logic [CNT_W-1:0]  count1;
    logic              err_underflow;

    modport master (
        output data_in, valid_in, selector,
        output pop0, pop1,
        input  ready_out,
        input  data_out0, data_out1,
        input  valid_out0, valid_out1,
        input  count0, count1,
        input  err_underflow
    );

    modport slave (
        input  data_in, valid_in, selector,
        input  pop0, pop1,
        output ready_out,
        output data_out0, data_out1,
        output valid_out0, valid_out1,
        output count0, count1,
        output err_underflow
    );
endinterface

// File: rtl/demux12_2bits_fifo.sv
// Registered 1:2 demux: one valid/ready stream split
// into two independent show-ahead lane FIFOs.
module demux12_2bits_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic clk,
    input  logic reset,
    demux12_2bits_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic              err_q;
    logic              err_d;

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] sel_oh;
    logic [1:0] pop_req;
    logic [1:0] push_l;
    logic [1:0] pop_l;
    logic       push;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            full[l]  = (cnt_q[l] == CNT_W'(DEPTH));
            empty[l] = (cnt_q[l] == '0);
        end
    end

    assign sel_oh  = {bus.selector, ~bus.selector};
    assign pop_req = {bus.pop1, bus.pop0};

    // Readiness follows only the addressed lane's stored
    // occupancy, so a pop never opens room the same cycle.
    assign bus.ready_out = ~(bus.selector ? full[1] : full[0]);
    assign push          = bus.valid_in & bus.ready_out;
    assign push_l        = sel_oh & {2{push}};
    assign pop_l         = pop_req & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | (|(pop_req & empty));
        for (int l = 0; l < 2; l++) begin
            if (push_l[l])
                wr_ptr_d[l] = wr_ptr_q[l] + PTR_W'(1);
            if (pop_l[l])
                rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(1);
            cnt_d[l] = cnt_q[l]
                     + CNT_W'(push_l[l])
                     - CNT_W'(pop_l[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Storage is left unreset; emptiness masks stale words.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!reset && push_l[l])
                mem_q[l][wr_ptr_q[l]] <= bus.data_in;
        end
    end

    assign bus.valid_out0 = ~empty[0];
    assign bus.valid_out1 = ~empty[1];
    assign bus.data_out0  = empty[0] ? '0
                          : mem_q[0][rd_ptr_q[0]];
    assign bus.data_out1  = empty[1] ? '0
                          : mem_q[1][rd_ptr_q[1]];
    assign bus.count0     = cnt_q[0];
    assign bus.count1     = cnt_q[1];
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_demux12_2bits_fifo.sv
// Directed bench for demux12_2bits_fifo: ordering, full
// back-pressure, wrap, underflow, steady state, reset.
module tb_demux12_2bits_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    demux12_2bits_fifo_if #(.DATA_W(2), .CNT_W(3)) bus ();

    demux12_2bits_fifo #(
        .DATA_W(2), .DEPTH(4), .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.valid_in = 1'b0;
        bus.pop0     = 1'b0;
        bus.pop1     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input bit lane, input logic [1:0] d);
        bus.selector = lane;
        bus.data_in  = d;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic pop(input bit lane);
        if (lane) bus.pop1 = 1'b1;
        else      bus.pop0 = 1'b1;
        @(posedge clk);
        #1;
        bus.pop0 = 1'b0;
        bus.pop1 = 1'b0;
    endtask

    task automatic test_reset();
        // Traffic during reset must be ignored.
        bus.selector = 1'b0;
        bus.data_in  = 2'b11;
        bus.valid_in = 1'b1;
        bus.pop0     = 1'b1;
        bus.pop1     = 1'b1;
        do_reset();
        idle();
        #1;
        checks++;
        if (bus.count0 !== 3'd0 || bus.count1 !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d,%0d exp=0,0",
                     bus.count0, bus.count1);
        end
        checks++;
        if (bus.valid_out0 !== 1'b0 || bus.valid_out1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b%b exp=00",
                     bus.valid_out0, bus.valid_out1);
        end
        checks++;
        if (bus.data_out0 !== 2'b00 || bus.data_out1 !== 2'b00) begin
            failures++;
            $display("FAIL reset_data got=%b,%b exp=00,00",
                     bus.data_out0, bus.data_out1);
        end
        checks++;
        if (bus.err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0",
                     bus.err_underflow);
        end
        checks++;
        if (bus.ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.ready_out);
        end
    endtask

    task automatic test_lane0_order();
        logic [1:0] exp_d [3];
        exp_d = '{2'b01, 2'b10, 2'b11};
        do_reset();
        push(1'b0, 2'b01);
        checks++;
        if (bus.valid_out0 !== 1'b1 || bus.data_out0 !== 2'b01) begin
            failures++;
            $display("FAIL latency got=%b/%b exp=1/01",
                     bus.valid_out0, bus.data_out0);
        end
        push(1'b0, 2'b10);
        push(1'b0, 2'b11);
        checks++;
        if (bus.count0 !== 3'd3 || bus.data_out0 !== 2'b01) begin
            failures++;
            $display("FAIL order_fill got=%0d/%b exp=3/01",
                     bus.count0, bus.data_out0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.data_out0 !== exp_d[i]) begin
                failures++;
                $display("FAIL order_head%0d got=%b exp=%b",
                         i, bus.data_out0, exp_d[i]);
            end
            pop(1'b0);
        end
        checks++;
        if (bus.valid_out0 !== 1'b0 || bus.count0 !== 3'd0) begin
            failures++;
            $display("FAIL order_empty got=%b/%0d exp=0/0",
                     bus.valid_out0, bus.count0);
        end
    endtask

    task automatic test_full_lane1();
        do_reset();
        for (int i = 0; i < 4; i++)
            push(1'b1, 2'(i));
        bus.selector = 1'b1;
        #1;
        checks++;
        if (bus.ready_out !== 1'b0) begin
            failures++;
            $display("FAIL full_ready1 got=%b exp=0", bus.ready_out);
        end
        bus.selector = 1'b0;
        #1;
        checks++;
        if (bus.ready_out !== 1'b1) begin
            failures++;
            $display("FAIL full_ready0 got=%b exp=1", bus.ready_out);
        end
        checks++;
        if (bus.count1 !== 3'd4) begin
            failures++;
            $display("FAIL full_count got=%0d exp=4", bus.count1);
        end
        // Push with pop on a full lane: pop taken, push refused.
        bus.selector = 1'b1;
        bus.data_in  = 2'b11;
        bus.valid_in = 1'b1;
        bus.pop1     = 1'b1;
        @(posedge clk);
        #1;
        idle();
        checks++;
        if (bus.count1 !== 3'd3 || bus.data_out1 !== 2'b01) begin
            failures++;
            $display("FAIL full_poppush got=%0d/%b exp=3/01",
                     bus.count1, bus.data_out1);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bus.data_out1 !== 2'(i)) begin
                failures++;
                $display("FAIL full_drain%0d got=%b exp=%0d",
                         i, bus.data_out1, i);
            end
            pop(1'b1);
        end
        checks++;
        if (bus.valid_out1 !== 1'b0) begin
            failures++;
            $display("FAIL full_empty got=%b exp=0", bus.valid_out1);
        end
    endtask

    task automatic test_alternate_wrap();
        logic [1:0] head0 [4];
        logic [1:0] newv [4];
        logic [1:0] fin0 [4];
        logic [1:0] fin1 [4];
        head0 = '{2'd0, 2'd2, 2'd0, 2'd2};
        newv  = '{2'd3, 2'd1, 2'd2, 2'd3};
        fin0  = '{2'd3, 2'd1, 2'd2, 2'd3};
        fin1  = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        for (int i = 0; i < 8; i++)
            push(i[0], 2'(i));
        checks++;
        if (bus.count0 !== 3'd4 || bus.count1 !== 3'd4) begin
            failures++;
            $display("FAIL alt_count got=%0d,%0d exp=4,4",
                     bus.count0, bus.count1);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (bus.data_out0 !== head0[j]) begin
                failures++;
                $display("FAIL alt_head%0d got=%b exp=%b",
                         j, bus.data_out0, head0[j]);
            end
            pop(1'b0);
            push(1'b0, newv[j]);
        end
        checks++;
        if (bus.count0 !== 3'd4 || bus.count1 !== 3'd4) begin
            failures++;
            $display("FAIL wrap_count got=%0d,%0d exp=4,4",
                     bus.count0, bus.count1);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (bus.data_out0 !== fin0[j] ||
                bus.data_out1 !== fin1[j]) begin
                failures++;
                $display("FAIL wrap_drain%0d got=%b,%b exp=%b,%b",
                         j, bus.data_out0, bus.data_out1,
                         fin0[j], fin1[j]);
            end
            bus.pop0 = 1'b1;
            pop(1'b1);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        pop(1'b0);
        checks++;
        if (bus.err_underflow !== 1'b1 || bus.count0 !== 3'd0) begin
            failures++;
            $display("FAIL uflow_set got=%b/%0d exp=1/0",
                     bus.err_underflow, bus.count0);
        end
        // Push and pop together on an empty lane.
        bus.pop0 = 1'b1;
        push(1'b0, 2'b01);
        bus.pop0 = 1'b0;
        checks++;
        if (bus.count0 !== 3'd1 || bus.data_out0 !== 2'b01) begin
            failures++;
            $display("FAIL uflow_pushpop got=%0d/%b exp=1/01",
                     bus.count0, bus.data_out0);
        end
        pop(1'b0);
        push(1'b1, 2'b10);
        checks++;
        if (bus.err_underflow !== 1'b1 || bus.count0 !== 3'd0) begin
            failures++;
            $display("FAIL uflow_sticky got=%b/%0d exp=1/0",
                     bus.err_underflow, bus.count0);
        end
        do_reset();
        checks++;
        if (bus.err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL uflow_clear got=%b exp=0",
                     bus.err_underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [10];
        logic [1:0] exp_o;
        seq = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1,
                2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
        do_reset();
        push(1'b0, 2'd3);
        push(1'b0, 2'd1);
        bus.selector = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      exp_o = 2'd3;
            else if (i == 1) exp_o = 2'd1;
            else             exp_o = seq[i-2];
            bus.data_in  = seq[i];
            bus.valid_in = 1'b1;
            bus.pop0     = 1'b1;
            #1;
            checks++;
            if (bus.data_out0 !== exp_o) begin
                failures++;
                $display("FAIL steady_out%0d got=%b exp=%b",
                         i, bus.data_out0, exp_o);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.count0 !== 3'd2) begin
                failures++;
                $display("FAIL steady_cnt%0d got=%0d exp=2",
                         i, bus.count0);
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 6; i++)
            push(i[0], 2'b11);
        checks++;
        if (bus.count0 !== 3'd3 || bus.count1 !== 3'd3) begin
            failures++;
            $display("FAIL mid_fill got=%0d,%0d exp=3,3",
                     bus.count0, bus.count1);
        end
        do_reset();
        checks++;
        if (bus.count0 !== 3'd0 || bus.count1 !== 3'd0 ||
            bus.valid_out0 !== 1'b0 || bus.valid_out1 !== 1'b0) begin
            failures++;
            $display("FAIL mid_state got=%0d,%0d,%b%b exp=0,0,00",
                     bus.count0, bus.count1,
                     bus.valid_out0, bus.valid_out1);
        end
        checks++;
        if (bus.data_out0 !== 2'b00 || bus.data_out1 !== 2'b00) begin
            failures++;
            $display("FAIL mid_data got=%b,%b exp=00,00",
                     bus.data_out0, bus.data_out1);
        end
    endtask

    initial begin
        bus.data_in  = 2'b00;
        bus.selector = 1'b0;
        idle();
        test_reset();
        test_lane0_order();
        test_full_lane1();
        test_alternate_wrap();
        test_underflow();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
